vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Pixel-generation stage directly downstream of the VGA timing generator. It consumes the pixel counters, valid flag and syncs, and fetches a 320x240 background (pixel-doubled to 640x480) from an external synchronous framebuffer. It overlays a solid square "cube" sprite whose position is taken once per frame. It drives 4:4:4 RGB with syncs delayed to match the memory read latency.

## Interface
- MEM_LAT, 2: framebuffer read latency in pclk edges, from `mem_addr` update to `mem_data` valid; legal range 1..4.
- CUBE_SIZE, 32: cube edge length in screen pixels; legal range 1..480.
- CUBE_COLOR, 12'h0F0: cube RGB as {R,G,B}, 4 bits each.

- pclk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  active-video flag from the timing generator.
- h_cnt  in  10  pixel column, 0..639; 0 outside active video.
- v_cnt  in  10  pixel row, 0..479; 0 outside active video.
- hsync_in  in  1  active-low horizontal sync.
- vsync_in  in  1  active-low vertical sync.
- cube_en  in  1  requested cube enable; sampled per frame.
- cube_x  in  10  requested cube left column; sampled per frame.
- cube_y  in  10  requested cube top row; sampled per frame.
- mem_rd  out  1  framebuffer read strobe.
- mem_addr  out  17  framebuffer word address.
- mem_data  in  12  framebuffer pixel {R,G,B}.
- vga_r, vga_g, vga_b  out  4 each  colour channels.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- frame_start  out  1  one-cycle pulse when new cube parameters take effect.

## Operation
- Stage 0, the address stage, is registered on the edge that samples the inputs:
  - mem_rd <= valid_in.
  - mem_addr <= valid_in ? (v_cnt>>1)*320 + (h_cnt>>1) : 0.
  - Address range is 0..76799, computed as 17-bit shift-add with no truncation.
- Cube hit is computed in stage 0 from the active cube registers:
  - hit = cube_en_a && valid_in && h_cnt >= cube_x_a && h_cnt < cube_x_a+CUBE_SIZE && v_cnt >= cube_y_a && v_cnt < cube_y_a+CUBE_SIZE.
  - Compares use 11-bit sums so there is no wrap.
- The delay line carries {valid, hit, hsync, vsync} for L = MEM_LAT+1 register stages.
- Output stage, at the same edge where mem_data is valid:
  - If the delayed valid is 0, RGB = 0.
  - Else if the delayed hit is 1, RGB = CUBE_COLOR.
  - Else RGB = mem_data.
- Frame latch:
  - vsync_prev is registered every cycle.
  - On vsync_prev=1 && vsync_in=0 (sync assertion edge), load the active registers from cube_en / cube_x / cube_y and pulse frame_start the next cycle.
  - Clamp cube_x_a = min(cube_x, 640-CUBE_SIZE) and cube_y_a = min(cube_y, 480-CUBE_SIZE).
  - Changes to cube_* mid-frame have no visible effect until the next vsync edge, so there is no tearing.
- Reset, at any time including mid-line:
  - Every output and pipeline stage reaches its reset value on the next edge.
  - Reset values:
    - vga_r/g/b = 0.
    - mem_rd = 0.
    - mem_addr = 0.
    - frame_start = 0.
    - hsync_out = vsync_out = 1.
    - Delay line flushed to valid=0, hit=0, syncs=1.
    - vsync_prev = 1, so no spurious frame_start.
    - cube_en_a = 0, cube_x_a = cube_y_a = 0.
- Sync-edge detection runs during reset but is overridden by it.

## Timing
- Input-to-output latency is L = MEM_LAT+1 edges for RGB, hsync_out, vsync_out and the implied valid; all four stay mutually aligned.
- mem_addr and mem_rd lag the inputs by exactly 1 edge.
- frame_start asserts 1 edge after the edge that sampled the vsync falling transition, and lasts exactly 1 cycle.
- Active registers update on that same edge, so the first pixel affected is the first active pixel after the sync.
- Simultaneous events:
  - Reset and a vsync edge in the same cycle: reset wins, with no pulse and no load.
  - Load and hit evaluation in the same cycle: hit uses the old values. This is only legal during blanking, where hit = 0 anyway.
- Throughput is one pixel per pclk with no stalls; mem_data is assumed valid on every cycle that has a read outstanding.

## Test plan
- Reset mid-line: assert reset with valid_in=1 and syncs low, then release. Required: vga_rgb=0, hsync_out=vsync_out=1, mem_rd=0 one edge after reset, with no frame_start pulse on release.
- Address mapping: drive h=639, v=479, valid=1. Required: mem_addr=76799 one edge later. Drive h=3, v=2. Required: mem_addr=321.
- Latency (MEM_LAT=2): a memory model returns data=addr[11:0] two edges after the address. Required: RGB at edge t+3 equals the model data for input t, and hsync_out equals hsync_in delayed by 3.
- Cube overlay: cube_en=1, x=100, y=50, CUBE_SIZE=32, then a vsync edge. Required: pixel (100,50) and (131,81) are 0F0; (99,50) and (132,50) are background.
- Clamp and defer: cube_x=700 is written mid-frame. Required: no change in the current frame; after the next vsync, frame_start pulses once and the cube covers columns 608..639.
- Blanking: valid_in=0 while mem_data=FFF. Required: RGB=0 after L edges.

Source files
------------

// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA timing generator: doubled 320x240 framebuffer fetch,
// per-frame latched square sprite overlay, and syncs delayed to match read latency.
module vga_pixel_pipe #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned CUBE_SIZE  = 32,
  parameter logic [11:0] CUBE_COLOR = 12'h0F0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cube_en,
  input  logic [9:0]  cube_x,
  input  logic [9:0]  cube_y,
  output logic        mem_rd,
  output logic [16:0] mem_addr,
  input  logic [11:0] mem_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int unsigned H_ACT  = 640;
  localparam int unsigned V_ACT  = 480;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned CMP_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_ACT - CUBE_SIZE);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_ACT - CUBE_SIZE);
  localparam logic [CMP_W-1:0] SIZE_W = CMP_W'(CUBE_SIZE);

  typedef struct packed {
    logic valid;
    logic hit;
    logic hsync;
    logic vsync;
  } dl_t;

  localparam dl_t DL_RST = '{valid: 1'b0, hit: 1'b0, hsync: 1'b1, vsync: 1'b1};

  logic              cube_en_a;
  logic [CNT_W-1:0]  cube_x_a;
  logic [CNT_W-1:0]  cube_y_a;
  logic              vsync_prev;
  dl_t               dl [MEM_LAT];

  logic [8:0]        fb_row_c;
  logic [8:0]        fb_col_c;
  logic [ADDR_W-1:0] addr_c;
  logic [CMP_W-1:0]  h_w_c;
  logic [CMP_W-1:0]  v_w_c;
  logic [CMP_W-1:0]  x_lo_c;
  logic [CMP_W-1:0]  y_lo_c;
  logic              hit_c;
  logic              vs_fall_c;
  logic [CNT_W-1:0]  x_clamp_c;
  logic [CNT_W-1:0]  y_clamp_c;
  dl_t               tap_c;
  logic [11:0]       rgb_c;

  // Row*320 as (row<<8)+(row<<6); all terms widened to 17 bits first.
  assign fb_row_c = v_cnt[9:1];
  assign fb_col_c = h_cnt[9:1];
  assign addr_c   = (ADDR_W'(fb_row_c) << 8) + (ADDR_W'(fb_row_c) << 6) + ADDR_W'(fb_col_c);

  // 11-bit window compare so x+SIZE never wraps.
  assign h_w_c  = {1'b0, h_cnt};
  assign v_w_c  = {1'b0, v_cnt};
  assign x_lo_c = {1'b0, cube_x_a};
  assign y_lo_c = {1'b0, cube_y_a};
  assign hit_c  = cube_en_a && valid_in &&
                  (h_w_c >= x_lo_c) && (h_w_c < x_lo_c + SIZE_W) &&
                  (v_w_c >= y_lo_c) && (v_w_c < y_lo_c + SIZE_W);

  assign vs_fall_c = vsync_prev && !vsync_in;
  assign x_clamp_c = (cube_x > X_MAX) ? X_MAX : cube_x;
  assign y_clamp_c = (cube_y > Y_MAX) ? Y_MAX : cube_y;

  // Oldest delay-line entry lines up with the mem_data answering its address.
  assign tap_c = dl[MEM_LAT-1];

  always_comb begin
    rgb_c = 12'h000;
    if (tap_c.valid) begin
      rgb_c = tap_c.hit ? CUBE_COLOR : mem_data;
    end
  end

  // Address stage.
  always_ff @(posedge pclk) begin
    if (reset) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd   <= valid_in;
      mem_addr <= valid_in ? addr_c : '0;
    end
  end

  // Control delay line; entry 0 is loaded alongside the address stage.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int unsigned k = 0; k < MEM_LAT; k++) begin
        dl[k] <= DL_RST;
      end
    end else begin
      dl[0] <= '{valid: valid_in, hit: hit_c, hsync: hsync_in, vsync: vsync_in};
      for (int unsigned k = 1; k < MEM_LAT; k++) begin
        dl[k] <= dl[k-1];
      end
    end
  end

  // Output stage: final delay-line slot for syncs and colour.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vga_r     <= 4'h0;
      vga_g     <= 4'h0;
      vga_b     <= 4'h0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vga_r     <= rgb_c[11:8];
      vga_g     <= rgb_c[7:4];
      vga_b     <= rgb_c[3:0];
      hsync_out <= tap_c.hsync;
      vsync_out <= tap_c.vsync;
    end
  end

  // Frame latch: cube parameters only change on the vsync assertion edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vsync_prev  <= 1'b1;
      frame_start <= 1'b0;
      cube_en_a   <= 1'b0;
      cube_x_a    <= '0;
      cube_y_a    <= '0;
    end else begin
      vsync_prev  <= vsync_in;
      frame_start <= vs_fall_c;
      if (vs_fall_c) begin
        cube_en_a <= cube_en;
        cube_x_a  <= x_clamp_c;
        cube_y_a  <= y_clamp_c;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe with a one-register synchronous framebuffer model.
module tb_vga_pixel_pipe;

  logic        pclk;
  logic        reset;
  logic        valid_in;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync_in;
  logic        vsync_in;
  logic        cube_en;
  logic [9:0]  cube_x;
  logic [9:0]  cube_y;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic [11:0] mem_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;

  logic [16:0] mem_q;
  logic        force_fff;
  int          n_cmp;
  int          n_err;

  vga_pixel_pipe #(.MEM_LAT(2), .CUBE_SIZE(32), .CUBE_COLOR(12'h0F0)) dut (
    .pclk        (pclk),
    .reset       (reset),
    .valid_in    (valid_in),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .cube_en     (cube_en),
    .cube_x      (cube_x),
    .cube_y      (cube_y),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Address registered once in the memory; data sampled by the DUT two edges after mem_addr updates.
  always_ff @(posedge pclk) mem_q <= mem_addr;
  assign mem_data = force_fff ? 12'hFFF : mem_q[11:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    h_cnt    = 10'd0;
    v_cnt    = 10'd0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  // One active pixel followed by blanking; the colour emerges three edges after it is sampled.
  task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic [11:0] exp);
    valid_in = 1'b1;
    h_cnt    = h;
    v_cnt    = v;
    step();
    idle();
    step();
    step();
    check(tag, 32'(rgb()), 32'(exp));
  endtask

  task automatic vsync_pulse(input string tag);
    vsync_in = 1'b0;
    step();
    check({tag, "_fs_hi"}, 32'(frame_start), 32'd1);
    vsync_in = 1'b1;
    step();
    check({tag, "_fs_lo"}, 32'(frame_start), 32'd0);
  endtask

  logic [9:0]  lat_h  [4];
  logic        lat_hs [4];
  logic [11:0] lat_d  [4];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    force_fff = 1'b0;
    cube_en   = 1'b0;
    cube_x    = 10'd0;
    cube_y    = 10'd0;

    // Reset mid-line with syncs low; also a vsync edge under reset must not pulse.
    reset    = 1'b1;
    valid_in = 1'b1;
    h_cnt    = 10'd10;
    v_cnt    = 10'd10;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    step();
    check("rst_rgb",   32'(rgb()),       32'h000);
    check("rst_hs",    32'(hsync_out),   32'd1);
    check("rst_vs",    32'(vsync_out),   32'd1);
    check("rst_mrd",   32'(mem_rd),      32'd0);
    check("rst_maddr", 32'(mem_addr),    32'd0);
    check("rst_fs",    32'(frame_start), 32'd0);
    step();
    check("rst_fs2",   32'(frame_start), 32'd0);
    idle();
    step();
    reset = 1'b0;
    step();
    check("rel_fs",  32'(frame_start), 32'd0);
    check("rel_rgb", 32'(rgb()),       32'h000);
    step();
    check("rel_fs2", 32'(frame_start), 32'd0);

    // Address mapping at the far corner and a small offset.
    valid_in = 1'b1;
    h_cnt    = 10'd639;
    v_cnt    = 10'd479;
    step();
    check("addr_max", 32'(mem_addr), 32'd76799);
    check("mrd_on",   32'(mem_rd),   32'd1);
    h_cnt = 10'd3;
    v_cnt = 10'd2;
    step();
    check("addr_321", 32'(mem_addr), 32'd321);
    idle();
    step();
    check("mrd_off",  32'(mem_rd),   32'd0);
    check("addr_0",   32'(mem_addr), 32'd0);

    // Streaming latency: row 4 -> addr 640 + h/2.
    lat_h  = '{10'd20, 10'd22, 10'd24, 10'd26};
    lat_hs = '{1'b1, 1'b0, 1'b0, 1'b1};
    lat_d  = '{12'h28A, 12'h28B, 12'h28C, 12'h28D};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        valid_in = 1'b1;
        h_cnt    = lat_h[i];
        v_cnt    = 10'd4;
        hsync_in = lat_hs[i];
      end else begin
        idle();
      end
      step();
      if (i >= 2) begin
        check($sformatf("lat_rgb%0d", i - 2), 32'(rgb()),     32'(lat_d[i-2]));
        check($sformatf("lat_hs%0d", i - 2),  32'(hsync_out), 32'(lat_hs[i-2]));
      end
    end
    step();
    check("lat_hs_idle", 32'(hsync_out), 32'd1);

    // Cube overlay at (100,50), size 32.
    cube_en = 1'b1;
    cube_x  = 10'd100;
    cube_y  = 10'd50;
    vsync_pulse("cube");
    probe("cube_tl",   10'd100, 10'd50, 12'h0F0);
    probe("cube_br",   10'd131, 10'd81, 12'h0F0);
    probe("cube_left", 10'd99,  10'd50, 12'hF71);
    probe("cube_rght", 10'd132, 10'd50, 12'hF82);

    // Mid-frame write is deferred, then clamped to 608 at the next frame.
    cube_x = 10'd700;
    probe("defer_old", 10'd100, 10'd50, 12'h0F0);
    check("defer_fs",  32'(frame_start), 32'd0);
    vsync_pulse("clamp");
    probe("clamp_608", 10'd608, 10'd50, 12'h0F0);
    probe("clamp_639", 10'd639, 10'd50, 12'h0F0);
    probe("clamp_607", 10'd607, 10'd50, 12'h06F);
    probe("clamp_old", 10'd100, 10'd50, 12'hF72);
    step();
    check("clamp_fs_once", 32'(frame_start), 32'd0);

    // Blanking forces black even when memory returns white.
    force_fff = 1'b1;
    probe("fff_active", 10'd0, 10'd0, 12'hFFF);
    idle();
    step();
    step();
    step();
    check("blank_rgb", 32'(rgb()), 32'h000);
    force_fff = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
